fb_write_responder: RTL and testbench

- Target (responder) end of the draw-source pixel write bus; the draw units (background, starfield, sprites) are the initiators.
- Each frame, grants the bus to sources 0..MAX_WRITE_SOURCE in fixed order and accepts pixels with a ready handshake.
- Converts each accepted pixel into a linear back-buffer memory write.
- Flips the front/back buffer select on the frame strobe only after a complete draw pass.

---
 rtl/fb_write_responder_pkg.sv | 25 ++
 rtl/fb_write_responder_if.sv | 31 +++
 rtl/fb_write_responder_addr_map.sv | 52 +++++
 rtl/fb_write_responder.sv | 117 +++++++++++
 tb/tb_fb_write_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_bus_pkg
// Description : Shared types and defaults for the draw-source pixel write bus.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCEPT = 2'd2
    } state_e;

    localparam int DEF_FB_WIDTH    = 640;
    localparam int DEF_FB_HEIGHT   = 480;
    localparam int DEF_COLOR_DEPTH = 9;

    // A single source still needs a one-bit select.
    function automatic int src_id_width(input int max_src);
        return (max_src < 1) ? 1 : $clog2(max_src + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_responder_if
// Description : Draw-source pixel write bus; draw units are masters.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_write_responder_if #(
    parameter int COLOR_DEPTH = 9,
    parameter int SRC_W       = 1
);
    logic [COLOR_DEPTH-1:0] write_color_data;
    logic [31:0]            write_x_addr;
    logic [31:0]            write_y_addr;
    logic                   write_transparent;
    logic                   write_active;
    logic                   write_awaited;
    logic [SRC_W-1:0]       write_source_sel;

    modport master (
        output write_color_data, write_x_addr, write_y_addr,
               write_transparent, write_active,
        input  write_awaited, write_source_sel
    );

    modport slave (
        input  write_color_data, write_x_addr, write_y_addr,
               write_transparent, write_active,
        output write_awaited, write_source_sel
    );
endinterface
`default_nettype wire

// File: rtl/fb_write_responder_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_map
// Description : Bounds check and linear address for accepted pixels, one
//               cycle of registered write latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_map
    import fb_bus_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int FB_WIDTH    = DEF_FB_WIDTH,
    parameter int FB_HEIGHT   = DEF_FB_HEIGHT,
    parameter int ADDR_WIDTH  = 19
) (
    input  wire logic                   clk,
    input  wire logic                   resetN,
    input  wire logic                   i_beat,
    input  wire logic [COLOR_DEPTH-1:0] i_color,
    input  wire logic [31:0]            i_x,
    input  wire logic [31:0]            i_y,
    input  wire logic                   i_transparent,
    output logic                        o_we,
    output logic [ADDR_WIDTH-1:0]       o_addr,
    output logic [COLOR_DEPTH-1:0]      o_wdata
);
    localparam logic [ADDR_WIDTH-1:0] c_WIDTH_A = ADDR_WIDTH'(FB_WIDTH);

    logic                  w_store;
    logic [ADDR_WIDTH-1:0] w_lin;

    assign w_store = i_beat && !i_transparent &&
                     (i_x < 32'(FB_WIDTH)) && (i_y < 32'(FB_HEIGHT));

    // Only the low ADDR_WIDTH bits of the product survive, so compute there.
    assign w_lin = i_y[ADDR_WIDTH-1:0] * c_WIDTH_A + i_x[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!resetN) begin
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
        end else begin
            o_we <= w_store;
            if (w_store) begin
                o_addr  <= w_lin;
                o_wdata <= i_color;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/fb_write_responder.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_responder
// Description : Grants draw sources in order each frame, turns accepted
//               pixels into back-buffer writes and flips buffers per pass.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_responder
    import fb_bus_pkg::*;
#(
    parameter int MAX_WRITE_SOURCE = 1,
    parameter int COLOR_DEPTH      = DEF_COLOR_DEPTH,
    parameter int FB_WIDTH         = DEF_FB_WIDTH,
    parameter int FB_HEIGHT        = DEF_FB_HEIGHT,
    parameter int ADDR_WIDTH       = 19
) (
    input  wire logic                  clk,
    input  wire logic                  resetN,
    input  wire logic                  frame,
    fb_write_responder_if.slave        wr,
    input  wire logic                  mem_ready,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [COLOR_DEPTH-1:0]     mem_wdata,
    output logic                       buf_sel,
    output logic                       pass_busy,
    output logic [7:0]                 overrun_cnt
);
    localparam int SRC_W = src_id_width(MAX_WRITE_SOURCE);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_GRANT  = 2'(GRANT);
    localparam logic [1:0] S_ACCEPT = 2'(ACCEPT);

    localparam logic [SRC_W-1:0] c_SRC_LAST = SRC_W'(MAX_WRITE_SOURCE);

    logic [1:0]       r_state;
    logic [SRC_W-1:0] r_src;
    logic             r_busy;
    logic             r_done;
    logic             r_buf;
    logic [7:0]       r_ovr;
    logic             w_awaited;
    logic             w_beat;

    assign w_awaited           = (r_state == S_ACCEPT) && mem_ready;
    assign w_beat              = wr.write_active && w_awaited;
    assign wr.write_awaited    = w_awaited;
    assign wr.write_source_sel = r_src;
    assign buf_sel             = r_buf;
    assign pass_busy           = r_busy;
    assign overrun_cnt         = r_ovr;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_buf   <= 1'b0;
            r_ovr   <= 8'd0;
        end else begin
            // A frame that lands mid-pass never flips; it is only counted.
            if (frame && r_busy && (r_ovr != 8'hFF))
                r_ovr <= r_ovr + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (frame) begin
                        if (r_done) begin
                            r_buf  <= ~r_buf;
                            r_done <= 1'b0;
                        end
                        r_src   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: r_state <= S_ACCEPT;
                S_ACCEPT: begin
                    // With mem_ready low the source is stalled, so its idle
                    // write_active cannot be trusted as end-of-pass.
                    if (mem_ready && !wr.write_active) begin
                        if (r_src < c_SRC_LAST) begin
                            r_src   <= r_src + 1'b1;
                            r_state <= S_GRANT;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fb_addr_map #(
        .COLOR_DEPTH (COLOR_DEPTH),
        .FB_WIDTH    (FB_WIDTH),
        .FB_HEIGHT   (FB_HEIGHT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_map (
        .clk           (clk),
        .resetN        (resetN),
        .i_beat        (w_beat),
        .i_color       (wr.write_color_data),
        .i_x           (wr.write_x_addr),
        .i_y           (wr.write_y_addr),
        .i_transparent (wr.write_transparent),
        .o_we          (mem_we),
        .o_addr        (mem_addr),
        .o_wdata       (mem_wdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_fb_write_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_responder
// Description : Directed self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_responder;
    import fb_bus_pkg::*;

    localparam int CD = 9;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          resetN;
    logic          frame;
    logic          mem_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [CD-1:0] mem_wdata;
    logic          buf_sel;
    logic          pass_busy;
    logic [7:0]    overrun_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+CD-1:0] sb_q[$];

    fb_write_responder_if #(.COLOR_DEPTH(CD), .SRC_W(1)) bus ();

    fb_write_responder #(
        .MAX_WRITE_SOURCE (1),
        .COLOR_DEPTH      (CD),
        .FB_WIDTH         (W),
        .FB_HEIGHT        (H),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .frame       (frame),
        .wr          (bus),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .buf_sel     (buf_sel),
        .pass_busy   (pass_busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record the beat about to be clocked, advance one edge, check the write port.
    task automatic clk_step();
        logic             exp_we;
        logic [31:0]      lin;
        logic [AW+CD-1:0] ent;
        #1;
        exp_we = 1'b0;
        if (resetN && bus.write_active && bus.write_awaited &&
            !bus.write_transparent && (bus.write_x_addr < W) && (bus.write_y_addr < H)) begin
            lin = bus.write_y_addr * W + bus.write_x_addr;
            sb_q.push_back({lin[AW-1:0], bus.write_color_data});
            exp_we = 1'b1;
        end
        @(posedge clk);
        #2;
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we && sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(ent[AW+CD-1:CD]));
            chk("mem_wdata", 32'(mem_wdata), 32'(ent[CD-1:0]));
        end
    endtask

    task automatic drive_px(input logic [31:0] x, input logic [31:0] y,
                            input logic [CD-1:0] c, input logic t);
        bus.write_x_addr      = x;
        bus.write_y_addr      = y;
        bus.write_color_data  = c;
        bus.write_transparent = t;
    endtask

    initial begin
        resetN         = 1'b0;
        frame          = 1'b0;
        mem_ready      = 1'b1;
        bus.write_active = 1'b0;
        drive_px(32'd0, 32'd0, 9'h000, 1'b0);

        // Reset state
        clk_step();
        clk_step();
        chk("rst_buf_sel", 32'(buf_sel), 32'd0);
        chk("rst_pass_busy", 32'(pass_busy), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_src_sel", 32'(bus.write_source_sel), 32'd0);
        chk("rst_awaited", 32'(bus.write_awaited), 32'd0);
        resetN = 1'b1;
        clk_step();

        // Single pixel from source 0
        frame = 1'b1;
        bus.write_active = 1'b1;
        drive_px(32'd3, 32'd2, 9'h1FF, 1'b0);
        clk_step();
        frame = 1'b0;
        chk("t1_busy", 32'(pass_busy), 32'd1);
        chk("t1_src0", 32'(bus.write_source_sel), 32'd0);
        chk("t1_grant_awaited", 32'(bus.write_awaited), 32'd0);
        clk_step();
        #1;
        chk("t1_accept_awaited", 32'(bus.write_awaited), 32'd1);
        clk_step();
        chk("t1_buf_sel", 32'(buf_sel), 32'd0);

        // Dropped beats still handshake; only the in-range pixel writes
        drive_px(32'd0, 32'd0, 9'h011, 1'b1);
        chk("t2_awaited_a", 32'(bus.write_awaited), 32'd1);
        clk_step();
        drive_px(32'd640, 32'd0, 9'h022, 1'b0);
        chk("t2_awaited_b", 32'(bus.write_awaited), 32'd1);
        clk_step();
        drive_px(32'd639, 32'd479, 9'h0A5, 1'b0);
        chk("t2_awaited_c", 32'(bus.write_awaited), 32'd1);
        clk_step();
        bus.write_active = 1'b0;
        clk_step();
        chk("t2_src1", 32'(bus.write_source_sel), 32'd1);
        chk("t2_grant_awaited", 32'(bus.write_awaited), 32'd0);
        clk_step();
        clk_step();
        chk("t2_pass_end_busy", 32'(pass_busy), 32'd0);
        chk("t2_buf_sel", 32'(buf_sel), 32'd0);

        // Two sources; this frame follows a completed pass so it flips
        frame = 1'b1;
        bus.write_active = 1'b1;
        drive_px(32'd10, 32'd1, 9'h0AA, 1'b0);
        clk_step();
        frame = 1'b0;
        chk("t3_flip", 32'(buf_sel), 32'd1);
        chk("t3_src0", 32'(bus.write_source_sel), 32'd0);
        clk_step();
        clk_step();
        drive_px(32'd11, 32'd1, 9'h0AB, 1'b0);
        clk_step();
        bus.write_active = 1'b0;
        clk_step();
        chk("t3_src1", 32'(bus.write_source_sel), 32'd1);
        chk("t3_grant_awaited", 32'(bus.write_awaited), 32'd0);
        chk("t3_busy", 32'(pass_busy), 32'd1);
        bus.write_active = 1'b1;
        drive_px(32'd5, 32'd0, 9'h055, 1'b0);
        clk_step();
        #1;
        chk("t3_accept_awaited", 32'(bus.write_awaited), 32'd1);

        // Frame while source 1 is active: overrun, no flip
        frame = 1'b1;
        clk_step();
        frame = 1'b0;
        chk("t4_overrun", 32'(overrun_cnt), 32'd1);
        chk("t4_no_flip", 32'(buf_sel), 32'd1);
        bus.write_active = 1'b0;
        clk_step();
        chk("t4_busy_low", 32'(pass_busy), 32'd0);
        chk("t4_buf_hold", 32'(buf_sel), 32'd1);
        frame = 1'b1;
        clk_step();
        frame = 1'b0;
        chk("t4_flip", 32'(buf_sel), 32'd0);
        chk("t4_overrun_hold", 32'(overrun_cnt), 32'd1);

        // mem_ready stall in ACCEPT
        bus.write_active = 1'b1;
        drive_px(32'd100, 32'd100, 9'h123, 1'b0);
        clk_step();
        mem_ready = 1'b0;
        #1;
        chk("t5_stall_awaited", 32'(bus.write_awaited), 32'd0);
        for (int i = 0; i < 5; i++) begin
            clk_step();
            chk("t5_stall_loop_awaited", 32'(bus.write_awaited), 32'd0);
        end
        chk("t5_src_hold", 32'(bus.write_source_sel), 32'd0);
        chk("t5_busy_hold", 32'(pass_busy), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("t5_resume_awaited", 32'(bus.write_awaited), 32'd1);
        clk_step();

        // Reset with a beat in flight
        drive_px(32'd1, 32'd1, 9'h001, 1'b0);
        resetN = 1'b0;
        clk_step();
        chk("t6_busy", 32'(pass_busy), 32'd0);
        chk("t6_buf_sel", 32'(buf_sel), 32'd0);
        chk("t6_overrun", 32'(overrun_cnt), 32'd0);
        chk("t6_src", 32'(bus.write_source_sel), 32'd0);
        chk("t6_awaited", 32'(bus.write_awaited), 32'd0);
        resetN = 1'b1;
        bus.write_active = 1'b0;
        clk_step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
